// File: rtl/mcdf_fmt_rcv_if.sv
// Formatter-to-receiver handshake plus the buffered output stream of mcdf_fmt_rcv.
// The slave modport is the receiver's view; the master modport is the formatter/sink side.
interface mcdf_fmt_rcv_if;
    logic        fmt_req;
    logic [1:0]  fmt_chid;
    logic        fmt_grant;
    logic        fmt_start;
    logic [31:0] fmt_data;
    logic        fmt_end;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_sop;
    logic        out_eop;
    logic [1:0]  out_chid;

    modport master (
        output fmt_req, fmt_chid, fmt_start, fmt_data, fmt_end, out_ready,
        input  fmt_grant, out_valid, out_data, out_sop, out_eop, out_chid
    );

    modport slave (
        input  fmt_req, fmt_chid, fmt_start, fmt_data, fmt_end, out_ready,
        output fmt_grant, out_valid, out_data, out_sop, out_eop, out_chid
    );
endinterface

// File: rtl/mcdf_fmt_rcv.sv
// Packet receiver: grants the formatter only when a whole max-length packet fits,
// stores tagged words in a first-word-fall-through buffer and flags protocol errors.
module mcdf_fmt_rcv #(
    parameter int DEPTH   = 64,
    parameter int MAX_LEN = 32,
    parameter int CNT_W   = 16
) (
    input  logic             clk_i,
    input  logic             rst_n,
    mcdf_fmt_rcv_if.slave    bus,
    input  logic             err_clr,
    output logic [CNT_W-1:0] pkt_cnt,
    output logic             err_nostart,
    output logic             err_len
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(MAX_LEN + 1);
    // A grant needs DEPTH - count >= MAX_LEN, i.e. count <= DEPTH - MAX_LEN.
    localparam logic [AW:0]   CNT_LIMIT = (AW + 1)'(DEPTH - MAX_LEN);
    localparam logic [LW-1:0] LAST_IDX  = LW'(MAX_LEN - 1);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        RECV
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      chid_q;
    logic [LW-1:0]   wcnt_q;
    logic [35:0]     mem [DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [AW:0]     count_q;
    logic            push, pop;
    logic            push_sop, push_eop;
    logic            set_nostart, set_len, pkt_done;
    logic [35:0]     rd_word;

    always_comb begin
        state_d       = state_q;
        push          = 1'b0;
        push_sop      = 1'b0;
        push_eop      = 1'b0;
        set_nostart   = 1'b0;
        set_len       = 1'b0;
        pkt_done      = 1'b0;
        bus.fmt_grant = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.fmt_req && (count_q <= CNT_LIMIT)) state_d = GRANT;
            end
            GRANT: begin
                bus.fmt_grant = 1'b1;
                state_d       = RECV;
            end
            RECV: begin
                if ((wcnt_q == '0) && !bus.fmt_start) begin
                    set_nostart = 1'b1;
                    state_d     = IDLE;
                end else begin
                    // After the first word, words arrive gap-free; a stray start is just data.
                    push     = 1'b1;
                    push_sop = (wcnt_q == '0);
                    push_eop = bus.fmt_end || (wcnt_q == LAST_IDX);
                    set_len  = (wcnt_q == LAST_IDX) && !bus.fmt_end;
                    pkt_done = push_eop;
                    if (push_eop) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign pop = bus.out_valid && bus.out_ready;

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            chid_q      <= '0;
            wcnt_q      <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            pkt_cnt     <= '0;
            err_nostart <= 1'b0;
            err_len     <= 1'b0;
        end else begin
            state_q <= state_d;
            if ((state_q == IDLE) && (state_d == GRANT)) chid_q <= bus.fmt_chid;
            if (state_q == GRANT)  wcnt_q <= '0;
            else if (push)         wcnt_q <= wcnt_q + 1'b1;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (pkt_done) pkt_cnt <= pkt_cnt + 1'b1;
            // Set beats clear when both happen in the same cycle.
            if (set_nostart)  err_nostart <= 1'b1;
            else if (err_clr) err_nostart <= 1'b0;
            if (set_len)      err_len <= 1'b1;
            else if (err_clr) err_len <= 1'b0;
        end
    end

    // Storage is data only; emptiness is tracked by the reset control above.
    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr_q] <= {chid_q, push_sop, push_eop, bus.fmt_data};
    end

    assign rd_word = mem[rd_ptr_q];

    // Outputs are forced to zero while empty so stale or uninitialised entries never show.
    always_comb begin
        bus.out_valid = (count_q != '0);
        bus.out_chid  = 2'b00;
        bus.out_sop   = 1'b0;
        bus.out_eop   = 1'b0;
        bus.out_data  = 32'h0;
        if (bus.out_valid) begin
            {bus.out_chid, bus.out_sop, bus.out_eop, bus.out_data} = rd_word;
        end
    end
endmodule

// File: tb/tb_mcdf_fmt_rcv.sv
// Directed bench for mcdf_fmt_rcv: grant/receive, 1-word packets, start and length errors,
// backpressure on the grant threshold and reset in the middle of a packet.
module tb_mcdf_fmt_rcv;
    localparam int DEPTH   = 64;
    localparam int MAX_LEN = 32;
    localparam int CNT_W   = 16;

    logic             clk_i = 1'b0;
    logic             rst_n;
    logic             err_clr;
    logic [CNT_W-1:0] pkt_cnt;
    logic             err_nostart;
    logic             err_len;

    int          checks = 0;
    int          errors = 0;
    logic [35:0] rxq [$];

    mcdf_fmt_rcv_if bus ();

    mcdf_fmt_rcv #(
        .DEPTH  (DEPTH),
        .MAX_LEN(MAX_LEN),
        .CNT_W  (CNT_W)
    ) dut (
        .clk_i      (clk_i),
        .rst_n      (rst_n),
        .bus        (bus),
        .err_clr    (err_clr),
        .pkt_cnt    (pkt_cnt),
        .err_nostart(err_nostart),
        .err_len    (err_len)
    );

    always #5 clk_i = ~clk_i;

    // Inputs change only just after a rising edge, so the falling edge sees what the next rising edge pops.
    always @(negedge clk_i) begin
        if (rst_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1)
            rxq.push_back({bus.out_chid, bus.out_sop, bus.out_eop, bus.out_data});
    end

    always @(negedge clk_i) begin
        if (rst_n === 1'b1 && dut.push === 1'b1 && dut.count_q >= DEPTH) begin
            $display("FAIL overflow push into full buffer count=%0d", dut.count_q);
            errors++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        bus.fmt_req   = 1'b0;
        bus.fmt_start = 1'b0;
        bus.fmt_end   = 1'b0;
        bus.fmt_data  = 32'h0;
    endtask

    task automatic req_grant(input logic [1:0] ch, input int max_cyc, output int lat, output bit got);
        bus.fmt_req  = 1'b1;
        bus.fmt_chid = ch;
        got = 1'b0;
        lat = 0;
        while (!got && lat < max_cyc) begin
            tick();
            lat++;
            if (bus.fmt_grant === 1'b1) got = 1'b1;
        end
        bus.fmt_req = 1'b0;
    endtask

    task automatic send(input logic s, input logic [31:0] d, input logic e);
        bus.fmt_start = s;
        bus.fmt_data  = d;
        bus.fmt_end   = e;
        tick();
    endtask

    task automatic wait_rx(input int n, input int max_cyc);
        int c;
        c = 0;
        while (rxq.size() < n && c < max_cyc) begin
            tick();
            c++;
        end
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        err_clr       = 1'b0;
        bus.out_ready = 1'b0;
        bus.fmt_chid  = 2'd0;
        idle_inputs();
        tick();
        tick();
        checks++;
        if ({bus.fmt_grant, bus.out_valid, bus.out_sop, bus.out_eop} !== 4'b0000) begin
            $display("FAIL reset_ctrl got=%b exp=0000", {bus.fmt_grant, bus.out_valid, bus.out_sop, bus.out_eop});
            errors++;
        end
        checks++;
        if (bus.out_data !== 32'h0) begin
            $display("FAIL reset_data got=%h exp=0", bus.out_data);
            errors++;
        end
        checks++;
        if (bus.out_chid !== 2'd0) begin
            $display("FAIL reset_chid got=%0d exp=0", bus.out_chid);
            errors++;
        end
        checks++;
        if (pkt_cnt !== '0) begin
            $display("FAIL reset_pkt_cnt got=%0d exp=0", pkt_cnt);
            errors++;
        end
        checks++;
        if ({err_nostart, err_len} !== 2'b00) begin
            $display("FAIL reset_err got=%b exp=00", {err_nostart, err_len});
            errors++;
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int lat;
        bit got;
        logic [35:0] exp;
        rxq.delete();
        bus.out_ready = 1'b1;
        req_grant(2'd2, 1, lat, got);
        checks++;
        if (got !== 1'b1) begin
            $display("FAIL basic_grant_latency got=%0d exp=1", got);
            errors++;
        end
        tick();
        checks++;
        if (bus.fmt_grant !== 1'b0) begin
            $display("FAIL basic_grant_width got=%b exp=0", bus.fmt_grant);
            errors++;
        end
        for (int i = 0; i < 4; i++) send(i == 0, 32'h1000 + 32'(i), i == 3);
        idle_inputs();
        wait_rx(4, 20);
        checks++;
        if (rxq.size() != 4) begin
            $display("FAIL basic_count got=%0d exp=4", rxq.size());
            errors++;
        end
        for (int i = 0; i < rxq.size() && i < 4; i++) begin
            exp = {2'd2, (i == 0), (i == 3), 32'h1000 + 32'(i)};
            checks++;
            if (rxq[i] !== exp) begin
                $display("FAIL basic_word%0d got=%h exp=%h", i, rxq[i], exp);
                errors++;
            end
        end
        checks++;
        if (pkt_cnt !== 16'd1) begin
            $display("FAIL basic_pkt_cnt got=%0d exp=1", pkt_cnt);
            errors++;
        end
    endtask

    task automatic test_one_word();
        int lat;
        bit got;
        rxq.delete();
        req_grant(2'd1, 1, lat, got);
        checks++;
        if (got !== 1'b1) begin
            $display("FAIL one_grant got=%0d exp=1", got);
            errors++;
        end
        tick();
        send(1'b1, 32'hDEADBEEF, 1'b1);
        idle_inputs();
        wait_rx(1, 20);
        repeat (3) tick();
        checks++;
        if (rxq.size() != 1) begin
            $display("FAIL one_count got=%0d exp=1", rxq.size());
            errors++;
        end else begin
            checks++;
            if (rxq[0] !== {2'd1, 1'b1, 1'b1, 32'hDEADBEEF}) begin
                $display("FAIL one_word got=%h exp=%h", rxq[0], {2'd1, 1'b1, 1'b1, 32'hDEADBEEF});
                errors++;
            end
        end
        checks++;
        if (pkt_cnt !== 16'd2) begin
            $display("FAIL one_pkt_cnt got=%0d exp=2", pkt_cnt);
            errors++;
        end
    endtask

    task automatic test_nostart();
        int lat;
        bit got;
        rxq.delete();
        req_grant(2'd0, 1, lat, got);
        tick();
        send(1'b0, 32'h55, 1'b0);
        checks++;
        if (err_nostart !== 1'b1) begin
            $display("FAIL nostart_set got=%b exp=1", err_nostart);
            errors++;
        end
        // Words with no grant outstanding must be ignored.
        send(1'b1, 32'h66, 1'b1);
        idle_inputs();
        repeat (5) tick();
        checks++;
        if (rxq.size() != 0) begin
            $display("FAIL nostart_nowrite got=%0d exp=0", rxq.size());
            errors++;
        end
        checks++;
        if (pkt_cnt !== 16'd2) begin
            $display("FAIL nostart_pkt_cnt got=%0d exp=2", pkt_cnt);
            errors++;
        end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checks++;
        if (err_nostart !== 1'b0) begin
            $display("FAIL nostart_clear got=%b exp=0", err_nostart);
            errors++;
        end
        req_grant(2'd0, 1, lat, got);
        tick();
        err_clr = 1'b1;
        send(1'b0, 32'h77, 1'b0);
        err_clr = 1'b0;
        checks++;
        if (err_nostart !== 1'b1) begin
            $display("FAIL nostart_set_wins got=%b exp=1", err_nostart);
            errors++;
        end
        idle_inputs();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
    endtask

    task automatic test_len();
        int lat;
        bit got;
        logic [35:0] exp;
        rxq.delete();
        bus.out_ready = 1'b1;
        req_grant(2'd3, 1, lat, got);
        checks++;
        if (got !== 1'b1) begin
            $display("FAIL len_grant got=%0d exp=1", got);
            errors++;
        end
        tick();
        for (int i = 0; i < 40; i++) send((i == 0) || (i == 5), 32'h2000 + 32'(i), 1'b0);
        idle_inputs();
        wait_rx(32, 60);
        repeat (5) tick();
        checks++;
        if (rxq.size() != 32) begin
            $display("FAIL len_count got=%0d exp=32", rxq.size());
            errors++;
        end
        for (int i = 0; i < rxq.size() && i < 32; i++) begin
            exp = {2'd3, (i == 0), (i == 31), 32'h2000 + 32'(i)};
            checks++;
            if (rxq[i] !== exp) begin
                $display("FAIL len_word%0d got=%h exp=%h", i, rxq[i], exp);
                errors++;
            end
        end
        checks++;
        if ({err_len, err_nostart} !== 2'b10) begin
            $display("FAIL len_flags got=%b exp=10", {err_len, err_nostart});
            errors++;
        end
        checks++;
        if (pkt_cnt !== 16'd3) begin
            $display("FAIL len_pkt_cnt got=%0d exp=3", pkt_cnt);
            errors++;
        end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checks++;
        if (err_len !== 1'b0) begin
            $display("FAIL len_clear got=%b exp=0", err_len);
            errors++;
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        bit got;
        logic [35:0] exp;
        rxq.delete();
        bus.out_ready = 1'b0;
        for (int p = 0; p < 3; p++) begin
            req_grant(2'(p), 1, lat, got);
            checks++;
            if (got !== 1'b1) begin
                $display("FAIL b2b_grant%0d got=%0d exp=1", p, got);
                errors++;
            end
            tick();
            for (int i = 0; i < 16; i++) send(i == 0, 32'h3000 + 32'(p * 16 + i), i == 15);
            idle_inputs();
        end
        // 48 words buffered: free is 16, below a full packet.
        req_grant(2'd3, 10, lat, got);
        checks++;
        if (got !== 1'b0) begin
            $display("FAIL b2b_withheld got=%0d exp=0", got);
            errors++;
        end
        checks++;
        if (rxq.size() != 0 || bus.out_valid !== 1'b1) begin
            $display("FAIL b2b_held got=%0d/%b exp=0/1", rxq.size(), bus.out_valid);
            errors++;
        end
        bus.out_ready = 1'b1;
        // 16 pops bring count to 32; that cycle grants, the grant shows after the 17th pop.
        req_grant(2'd3, 60, lat, got);
        checks++;
        if (got !== 1'b1 || lat != 17) begin
            $display("FAIL b2b_resume got=%0d lat=%0d exp=1 lat=17", got, lat);
            errors++;
        end
        tick();
        for (int i = 0; i < 16; i++) send(i == 0, 32'h3000 + 32'(48 + i), i == 15);
        idle_inputs();
        wait_rx(64, 200);
        checks++;
        if (rxq.size() != 64) begin
            $display("FAIL b2b_count got=%0d exp=64", rxq.size());
            errors++;
        end
        for (int i = 0; i < rxq.size() && i < 64; i++) begin
            exp = {2'(i / 16), (i % 16 == 0), (i % 16 == 15), 32'h3000 + 32'(i)};
            checks++;
            if (rxq[i] !== exp) begin
                $display("FAIL b2b_word%0d got=%h exp=%h", i, rxq[i], exp);
                errors++;
            end
        end
        checks++;
        if (pkt_cnt !== 16'd7) begin
            $display("FAIL b2b_pkt_cnt got=%0d exp=7", pkt_cnt);
            errors++;
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        bit got;
        rxq.delete();
        bus.out_ready = 1'b0;
        req_grant(2'd1, 1, lat, got);
        tick();
        send(1'b1, 32'hA0, 1'b1);
        req_grant(2'd2, 1, lat, got);
        tick();
        send(1'b1, 32'hB0, 1'b0);
        send(1'b0, 32'hB1, 1'b0);
        checks++;
        if (bus.out_valid !== 1'b1 || pkt_cnt !== 16'd8) begin
            $display("FAIL rstmid_pre got=%b/%0d exp=1/8", bus.out_valid, pkt_cnt);
            errors++;
        end
        bus.fmt_data = 32'hB2;
        rst_n = 1'b0;
        tick();
        checks++;
        if ({bus.out_valid, bus.fmt_grant, bus.out_sop, bus.out_eop} !== 4'b0000) begin
            $display("FAIL rstmid_ctrl got=%b exp=0000", {bus.out_valid, bus.fmt_grant, bus.out_sop, bus.out_eop});
            errors++;
        end
        checks++;
        if (bus.out_data !== 32'h0 || bus.out_chid !== 2'd0) begin
            $display("FAIL rstmid_data got=%h/%0d exp=0/0", bus.out_data, bus.out_chid);
            errors++;
        end
        checks++;
        if (pkt_cnt !== '0) begin
            $display("FAIL rstmid_pkt_cnt got=%0d exp=0", pkt_cnt);
            errors++;
        end
        rst_n = 1'b1;
        idle_inputs();
        bus.out_ready = 1'b1;
        repeat (5) tick();
        checks++;
        if (rxq.size() != 0 || bus.out_valid !== 1'b0) begin
            $display("FAIL rstmid_flushed got=%0d/%b exp=0/0", rxq.size(), bus.out_valid);
            errors++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_one_word();
        test_nostart();
        test_len();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
